// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store ports, the arbiter and the RAM.
// slave = arbiter side, master = requester/RAM side.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the instruction-fetch
// and load/store ports; sequences the fixed RAM read latency.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RAM_LAT = 1
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic {PORT_IF, PORT_D} port_t;

    state_t        state_q;
    port_t         last_q;
    port_t         win_q;
    port_t         win_d;
    logic          contested;
    logic          wr_q;
    logic [1:0]    cnt_q;

    logic          if_gnt_q;
    logic          if_rvalid_q;
    logic [DW-1:0] if_rdata_q;
    logic          d_gnt_q;
    logic          d_rvalid_q;
    logic [DW-1:0] d_rdata_q;
    logic          ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;

    // On conflict the port that lost the previous contested round wins.
    always_comb begin
        contested = bus.if_req && bus.d_req;
        win_d     = PORT_IF;
        if (contested)
            win_d = (last_q == PORT_IF) ? PORT_D : PORT_IF;
        else if (bus.d_req)
            win_d = PORT_D;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= PORT_IF;
            win_q       <= PORT_IF;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            if_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_gnt_q     <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        win_q   <= win_d;
                        state_q <= S_ISSUE;
                        if (contested)
                            last_q <= win_d;
                        if (win_d == PORT_D) begin
                            ram_addr_q  <= bus.d_addr;
                            ram_wdata_q <= bus.d_wdata;
                            ram_we_q    <= bus.d_we;
                            wr_q        <= bus.d_we;
                            d_gnt_q     <= 1'b1;
                        end else begin
                            ram_addr_q  <= bus.if_addr;
                            ram_we_q    <= 1'b0;
                            wr_q        <= 1'b0;
                            if_gnt_q    <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if_gnt_q <= 1'b0;
                    d_gnt_q  <= 1'b0;
                    ram_we_q <= 1'b0;
                    cnt_q    <= 2'(RAM_LAT - 1);
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RESP;
                        if (win_q == PORT_D) begin
                            d_rdata_q  <= wr_q ? '0 : bus.ram_rdata;
                            d_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= bus.ram_rdata;
                            if_rvalid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                S_RESP: begin
                    if_rvalid_q <= 1'b0;
                    d_rvalid_q  <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RAM_LAT=1, one with RAM_LAT=3.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
    mem_arbiter_if #(.AW(32), .DW(32)) b3 ();

    mem_arbiter #(.AW(32), .DW(32), .RAM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
    mem_arbiter #(.AW(32), .DW(32), .RAM_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: 1-stage and 3-stage read pipelines, preloaded during reset.
    logic [31:0] mem1 [256];
    logic [31:0] rd1;
    logic [31:0] mem3 [256];
    logic [31:0] p1, p2, p3;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'(i);
            mem1[8'h10] <= 32'hDEADBEEF;
            mem1[8'h40] <= 32'hCAFEF00D;
        end else if (b1.ram_we) begin
            mem1[b1.ram_addr[7:0]] <= b1.ram_wdata;
        end
        rd1 <= mem1[b1.ram_addr[7:0]];
    end
    assign b1.ram_rdata = rd1;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 32'(i);
            mem3[8'h30] <= 32'h55AA33CC;
        end else if (b3.ram_we) begin
            mem3[b3.ram_addr[7:0]] <= b3.ram_wdata;
        end
        p1 <= mem3[b3.ram_addr[7:0]];
        p2 <= p1;
        p3 <= p2;
    end
    assign b3.ram_rdata = p3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int gcyc [4];
    int gwho [4];
    int ng;
    int both;
    int stray;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
        b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
        tick(); tick();

        // Reset values
        chk("rst_if_gnt",   32'(b1.if_gnt),    32'd0);
        chk("rst_d_gnt",    32'(b1.d_gnt),     32'd0);
        chk("rst_rvalid",   32'({b1.if_rvalid, b1.d_rvalid}), 32'd0);
        chk("rst_ram_we",   32'(b1.ram_we),    32'd0);
        chk("rst_ram_addr", b1.ram_addr,       32'd0);
        chk("rst_if_rdata", b1.if_rdata,       32'd0);
        chk("rst_d_rdata",  b1.d_rdata,        32'd0);
        reset = 1'b0;
        tick();

        // Single fetch read, RAM_LAT=1 (cycle T)
        b1.if_req = 1; b1.if_addr = 32'h10;
        tick();                                            // T+1
        chk("f_gnt",      32'(b1.if_gnt),   32'd1);
        chk("f_d_gnt",    32'(b1.d_gnt),    32'd0);
        chk("f_ram_addr", b1.ram_addr,      32'h10);
        chk("f_ram_we",   32'(b1.ram_we),   32'd0);
        b1.if_req = 0;
        tick();                                            // T+2
        chk("f_gnt_off",  32'(b1.if_gnt),   32'd0);
        chk("f_rv_early", 32'(b1.if_rvalid), 32'd0);
        tick();                                            // T+3
        chk("f_rvalid",   32'(b1.if_rvalid), 32'd1);
        chk("f_rdata",    b1.if_rdata,      32'hDEADBEEF);
        tick();                                            // T+4
        chk("f_rv_off",   32'(b1.if_rvalid), 32'd0);

        // Data write (cycle T)
        b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h20; b1.d_wdata = 32'h12345678;
        tick();                                            // T+1
        chk("w_gnt",      32'(b1.d_gnt),    32'd1);
        chk("w_ram_we",   32'(b1.ram_we),   32'd1);
        chk("w_ram_addr", b1.ram_addr,      32'h20);
        chk("w_ram_wd",   b1.ram_wdata,     32'h12345678);
        b1.d_req = 0; b1.d_we = 0;
        tick();                                            // T+2
        chk("w_we_once",  32'(b1.ram_we),   32'd0);
        tick();                                            // T+3
        chk("w_rvalid",   32'(b1.d_rvalid), 32'd1);
        chk("w_rdata0",   b1.d_rdata,       32'd0);
        chk("w_if_hold",  b1.if_rdata,      32'hDEADBEEF);
        chk("w_if_rv",    32'(b1.if_rvalid), 32'd0);
        tick();                                            // T+4, IDLE

        // Read-back of 0x20, d_addr changed the cycle after grant
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h20;
        tick();                                            // T+1
        chk("r_gnt",      32'(b1.d_gnt),    32'd1);
        b1.d_req = 0;
        tick();                                            // T+2
        chk("r_addr_w",   b1.ram_addr,      32'h20);
        b1.d_addr = 32'h77;
        tick();                                            // T+3
        chk("r_addr_rsp", b1.ram_addr,      32'h20);
        chk("r_rvalid",   32'(b1.d_rvalid), 32'd1);
        chk("r_rdata",    b1.d_rdata,       32'h12345678);
        tick();

        // Contention from reset release: expect D, IF, D, IF at +1, +5, +9, +13
        reset = 1'b1;
        b1.if_req = 1; b1.if_addr = 32'h10;
        b1.d_req  = 1; b1.d_we = 0; b1.d_addr = 32'h40;
        tick();
        reset = 1'b0;
        ng = 0; both = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (b1.if_gnt && b1.d_gnt) both++;
            if ((b1.if_gnt || b1.d_gnt) && ng < 4) begin
                gcyc[ng] = c;
                gwho[ng] = b1.d_gnt ? 1 : 0;
                ng++;
            end
        end
        b1.if_req = 0; b1.d_req = 0;
        chk("c_ngrants", 32'(ng),   32'd4);
        chk("c_both",    32'(both), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("c_cycle", 32'(gcyc[k]), 32'(1 + 4 * k));
            chk("c_who",   32'(gwho[k]), ((k % 2) == 0) ? 32'd1 : 32'd0);
        end
        chk("c_d_rdata",  b1.d_rdata,  32'hCAFEF00D);
        chk("c_if_rdata", b1.if_rdata, 32'hDEADBEEF);
        tick();

        // Latency sweep on RAM_LAT=3 (cycle T)
        b3.if_req = 1; b3.if_addr = 32'h30;
        tick();                                            // T+1
        chk("l_gnt",  32'(b3.if_gnt), 32'd1);
        chk("l_a1",   b3.ram_addr,    32'h30);
        b3.if_req = 0; b3.if_addr = 32'h31;
        for (int k = 2; k <= 4; k++) begin
            tick();                                        // T+2..T+4
            chk("l_addr_hold", b3.ram_addr, 32'h30);
            chk("l_no_rv", 32'({b3.if_rvalid, b3.if_gnt}), 32'd0);
        end
        tick();                                            // T+5
        chk("l_rvalid", 32'(b3.if_rvalid), 32'd1);
        chk("l_rdata",  b3.if_rdata,       32'h55AA33CC);
        tick();
        chk("l_rv_off", 32'(b3.if_rvalid), 32'd0);

        // Reset mid-WAIT on a data read
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h40;
        tick();                                            // T+1
        chk("m_gnt", 32'(b1.d_gnt), 32'd1);
        b1.d_req = 0;
        tick();                                            // T+2, WAIT
        reset = 1'b1;
        #1;
        chk("m_ram_we",  32'(b1.ram_we), 32'd0);
        chk("m_gnts",    32'({b1.if_gnt, b1.d_gnt}), 32'd0);
        chk("m_rvalids", 32'({b1.if_rvalid, b1.d_rvalid}), 32'd0);
        chk("m_d_rdata", b1.d_rdata, 32'd0);
        tick();
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (b1.d_rvalid) stray++;
        end
        chk("m_no_rvalid", 32'(stray), 32'd0);

        b1.if_req = 1; b1.if_addr = 32'h10;
        tick();
        chk("m2_gnt", 32'(b1.if_gnt), 32'd1);
        b1.if_req = 0;
        tick(); tick();
        chk("m2_rvalid", 32'(b1.if_rvalid), 32'd1);
        chk("m2_rdata",  b1.if_rdata,       32'hDEADBEEF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port `ram` between the CPU instruction-fetch port and the CPU load/store port. It sits between `riscv_cpu` and `ram` in `top`. It serialises accesses with round-robin priority on conflict, sequences the RAM's fixed read latency, and returns a one-cycle response pulse to the winning requester.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width.
- `RAM_LAT`, 1: RAM read latency in cycles. Legal range 1..4.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `if_req` in 1: fetch request. Held until `if_gnt`.
- `if_addr` in AW: fetch address.
- `if_gnt` out 1: one-cycle grant pulse to the fetch port.
- `if_rvalid` out 1: one-cycle response pulse to the fetch port.
- `if_rdata` out DW: fetch data, valid with `if_rvalid`.
- `d_req` in 1: data request. Held until `d_gnt`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in AW: data address.
- `d_wdata` in DW: write data.
- `d_gnt` out 1: one-cycle grant pulse to the data port.
- `d_rvalid` out 1: one-cycle completion pulse for reads and writes.
- `d_rdata` out DW: read data, valid with `d_rvalid`.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out AW: RAM address.
- `ram_wdata` out DW: RAM write data.
- `ram_rdata` in DW: RAM read data, valid RAM_LAT cycles after the address is presented.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- **IDLE**
  - Sample `if_req` and `d_req`. If neither is high, stay in IDLE.
  - One request high: it wins.
  - Both high: the port that did not win the last contested arbitration wins. The `last_winner` register updates only on contested cycles; it resets to IF, so the first conflict goes to data.
  - On a win, latch the winner's address, we and wdata into the `ram_*` registers, latch the winner ID, and go to ISSUE.
- **ISSUE** (1 cycle)
  - The winner's `*_gnt` = 1.
  - `ram_addr` and `ram_wdata` are driven.
  - `ram_we` = 1 only for a data write. The fetch port is read-only and always has we = 0.
  - Go to WAIT with the wait counter = RAM_LAT-1.
- **WAIT** (RAM_LAT cycles)
  - `ram_addr` is held and `ram_we` = 0.
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, register `ram_rdata` into the winner's rdata register (a write registers 0), then go to RESP.
- **RESP** (1 cycle)
  - The winner's `*_rvalid` = 1 and `*_rdata` is valid.
  - The non-winner's rdata is unchanged.
  - Always go to IDLE.
- A requester may drop `req` after its `gnt`. A `req` still high in IDLE counts as a new request.
- Address and data inputs are sampled only in IDLE. Changes at other times are ignored.
- `*_rdata` holds its value until the next response to the same port.
- `ram_addr` and `ram_wdata` hold their last value in IDLE.

## Timing
- Reset values:
  - state = IDLE, last_winner = IF.
  - All gnt, rvalid and `ram_we` = 0.
  - `ram_addr`, `ram_wdata`, `if_rdata`, `d_rdata` = 0.
- Latency, with the request sampled in IDLE at cycle T:
  - gnt and RAM address in cycle T+1.
  - RAM data captured at the end of cycle T+1+RAM_LAT.
  - rvalid in cycle T+2+RAM_LAT.
- The earliest next grant is in cycle T+4+RAM_LAT. With `req` held continuously, one access completes every RAM_LAT+3 cycles.
- At most one gnt and one rvalid are high in any cycle. gnt and rvalid are never high in the same cycle.
- A request arriving in ISSUE, WAIT or RESP waits until the next IDLE.
- Reset asserted mid-transaction:
  - All outputs return to their reset values immediately (asynchronously).
  - No rvalid is issued for the aborted access.
  - A write already presented in ISSUE may have completed in the RAM; the arbiter does not track it.
- With RAM_LAT = 1, WAIT lasts exactly one cycle.

## Test plan
- **Single fetch read**, RAM_LAT=1, RAM[0x10]=0xDEADBEEF:
  - Stimulus: `if_req`=1, `if_addr`=0x10 sampled in cycle T.
  - Required: `if_gnt` in T+1; `if_rvalid`=1 with `if_rdata`=0xDEADBEEF in T+3 only.
- **Data write then read-back**:
  - Stimulus: `d_we`=1, `d_addr`=0x20, `d_wdata`=0x12345678.
  - Required for the write: `ram_we`=1 for exactly one cycle; `d_rvalid` with `d_rdata`=0.
  - Stimulus: a read of 0x20.
  - Required for the read: `d_rdata`=0x12345678.
- **Contention**:
  - Stimulus: `if_req` and `d_req` both held high from reset release for 4 grants.
  - Required: grant order D, IF, D, IF; gnts spaced RAM_LAT+3 cycles apart; never two gnts in one cycle.
- **Latency sweep**:
  - Stimulus: RAM_LAT=3, fetch read sampled in cycle T.
  - Required: `if_gnt` in T+1; `ram_addr` stable T+1..T+4; `if_rvalid` in T+5 with the correct data.
- **Reset mid-WAIT**:
  - Stimulus: assert `reset` in the cycle after a data read's grant.
  - Required: `ram_we`, gnts and rvalids = 0 and `d_rdata`=0 immediately; no `d_rvalid` after release; the next request is served normally.
- **Input change after grant**:
  - Stimulus: change `d_addr` in the cycle after `d_gnt`.
  - Required: `ram_addr` keeps the originally sampled address until RESP.
